// File: rtl/mbist_march_ctrl_pkg.sv
// Shared definitions for the March C- memory BIST controller: state
// encoding, per-state element attributes and small decode helpers.
package mbist_march_ctrl_pkg;

    localparam int ADDR_W_DFLT = 3;
    localparam int DATA_W_DFLT = 16;

    // IDLE, six March elements, DONE. Element index = state - 1.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M0   = 3'd1,
        ST_M1   = 3'd2,
        ST_M2   = 3'd3,
        ST_M3   = 3'd4,
        ST_M4   = 3'd5,
        ST_M5   = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    // Per-state attribute tables, bit i describes state encoding i.
    // IDLE (bit 0) and DONE (bit 7) carry no memory operation.
    localparam logic [7:0] ST_MARCH  = 8'b0111_1110; // M0..M5
    localparam logic [7:0] ST_DOWN   = 8'b0011_0000; // M3, M4 walk N-1..0
    localparam logic [7:0] ST_HAS_RD = 8'b0111_1100; // M1..M5 read first
    localparam logic [7:0] ST_HAS_WR = 8'b0011_1110; // M0..M4 write
    localparam logic [7:0] ST_RD_D1  = 8'b0010_1000; // M2, M4 expect D1
    localparam logic [7:0] ST_WR_D1  = 8'b0001_0100; // M1, M3 write D1

    // Memory depth for a given address width.
    function automatic int mem_depth(input int addr_w);
        return 32'd1 << addr_w;
    endfunction

    // March element index reported in the failure capture.
    function automatic logic [2:0] elem_of(input state_e s);
        logic [2:0] v;
        v = s;
        return v - 3'd1;
    endfunction

    // Element that follows the given one; M5 ends the test.
    function automatic state_e next_elem_state(input state_e s);
        state_e n;
        case (s)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_DONE;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mbist_march_ctrl_addr_gen.sv
// Up/down address counter for the March sequencer. A load places the
// counter at the first address of the next element; o_last flags the
// final address of the current walk direction.
module mbist_addr_gen #(
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_load_down,
    input  logic              i_step,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] ADDR_MIN = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

    logic [ADDR_W-1:0] r_addr;

    // Address register: load wins over step so element changes cost no cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr <= ADDR_MIN;
        end else if (i_load) begin
            r_addr <= i_load_down ? ADDR_MAX : ADDR_MIN;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
        end else begin
            r_addr <= r_addr;
        end
    end

    assign o_addr = r_addr;
    assign o_last = i_down ? (r_addr == ADDR_MIN) : (r_addr == ADDR_MAX);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller. Owns the data-memory port while a test
// runs, compares read data against the expected background and keeps the
// first failing address, element and data.
module mbist_march_ctrl
    import mbist_march_ctrl_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DFLT,
    parameter int                DATA_W       = DATA_W_DFLT,
    parameter logic [DATA_W-1:0] BG_PATTERN   = {DATA_W{1'b0}},
    parameter bit                STOP_ON_FAIL = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bist_start,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_mem_sel,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic              o_bist_busy,
    output logic              o_bist_done,
    output logic              o_bist_fail,
    output logic [ADDR_W-1:0] o_fail_addr,
    output logic [2:0]        o_fail_elem,
    output logic [DATA_W-1:0] o_fail_data
);

    localparam logic [DATA_W-1:0] D0 = BG_PATTERN;
    localparam logic [DATA_W-1:0] D1 = ~BG_PATTERN;

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_phase;       // 0 = read op, 1 = write op of a two-op element
    logic              w_phase_nxt;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [2:0]        r_fail_elem;
    logic [DATA_W-1:0] r_fail_data;

    logic              w_march;
    logic              w_down;
    logic              w_has_rd;
    logic              w_has_wr;
    logic              w_rd;
    logic              w_wr;
    logic              w_op_end;
    logic [DATA_W-1:0] w_exp;
    logic [DATA_W-1:0] w_wdata;
    logic              w_mismatch;
    logic              w_start;
    logic              w_load;
    logic              w_load_down;
    logic              w_step;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    // Operation decode for the current state and phase.
    assign w_march    = ST_MARCH[r_state];
    assign w_down     = ST_DOWN[r_state];
    assign w_has_rd   = ST_HAS_RD[r_state];
    assign w_has_wr   = ST_HAS_WR[r_state];
    assign w_rd       = w_has_rd & ~r_phase;
    assign w_wr       = w_has_wr & (r_phase | ~w_has_rd);
    assign w_op_end   = w_march & (r_phase | ~(w_has_rd & w_has_wr));
    assign w_exp      = ST_RD_D1[r_state] ? D1 : D0;
    assign w_wdata    = w_wr ? (ST_WR_D1[r_state] ? D1 : D0) : {DATA_W{1'b0}};
    assign w_mismatch = w_rd & (i_mem_rdata != w_exp);
    assign w_start    = ((r_state == ST_IDLE) || (r_state == ST_DONE)) & i_bist_start;

    mbist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_load_down (w_load_down),
        .i_step      (w_step),
        .i_down      (w_down),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    // State and phase registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_phase <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_busy  <= ST_MARCH[w_state_nxt];
        end
    end

    // Next-state, phase and address-counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_load      = 1'b0;
        w_load_down = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_bist_start) begin
                    w_state_nxt = ST_M0;
                    w_phase_nxt = 1'b0;
                    w_load      = 1'b1;
                    w_load_down = 1'b0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                if (w_mismatch && STOP_ON_FAIL) begin
                    w_state_nxt = ST_DONE;
                    w_phase_nxt = 1'b0;
                end else if (w_op_end) begin
                    w_phase_nxt = 1'b0;
                    if (w_last) begin
                        // Jump straight to the next element's start address.
                        w_state_nxt = next_elem_state(r_state);
                        w_load      = 1'b1;
                        w_load_down = ST_DOWN[w_state_nxt];
                    end else begin
                        w_step = 1'b1;
                    end
                end else begin
                    w_phase_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // Done flag and first-failure capture; a new start clears the result.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start) begin
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_fail_addr <= {ADDR_W{1'b0}};
            r_fail_elem <= 3'd0;
            r_fail_data <= {DATA_W{1'b0}};
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
            if (w_mismatch && !r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= w_addr;
                r_fail_elem <= elem_of(r_state);
                r_fail_data <= i_mem_rdata;
            end else begin
                r_fail      <= r_fail;
                r_fail_addr <= r_fail_addr;
                r_fail_elem <= r_fail_elem;
                r_fail_data <= r_fail_data;
            end
        end
    end

    assign o_mem_sel   = r_busy;
    assign o_bist_busy = r_busy;
    assign o_mem_addr  = w_march ? w_addr : {ADDR_W{1'b0}};
    assign o_mem_wdata = w_wdata;
    assign o_mem_we    = w_wr;
    assign o_mem_re    = w_rd;
    assign o_bist_done = r_done;
    assign o_bist_fail = r_fail;
    assign o_fail_addr = r_fail_addr;
    assign o_fail_elem = r_fail_elem;
    assign o_fail_data = r_fail_data;

endmodule
